// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/acknowledge data-memory bus between the MEM-stage
// access controller (master) and the wait-stated data memory (slave).
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle load/store controller for the MEM stage.
// Freezes the pipeline while a req/ack access runs on the data-memory bus,
// forces a bus error after TIMEOUT unacknowledged request cycles, and
// aligns/extends load data into the registered `read` word.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses are trapped
// in IDLE (no bus cycle, AddrExc pulse) instead of ignoring low address bits.
module data_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic              Stall,
    output logic [31:0]       read,
    output logic              ReadValid,
    output logic              BusError,
    output logic              AddrExc,
    data_mem_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Counter value seen during the last permitted request cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       we_q, uns_q, err_q, exc_q;
    logic [1:0] size_q, off_q;
    logic [7:0] cnt_q;
    logic       start, trap, finish_ok, finish_to, misaligned, stall_c;

    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((Size == 2'b01) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, stall and access start/finish decode.
    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        start     = 1'b0;
        trap      = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    // Gated so that Stall reads 0 while reset is held.
                    stall_c = rst_n;
                    start   = 1'b1;
                    if (misaligned) begin
                        trap    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus.bus_ack) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    finish_to = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Stall       = stall_c;
    assign bus.bus_req = (state_q == REQ);
    assign ReadValid   = (state_q == DONE) && !we_q && !err_q && !exc_q;
    assign BusError    = (state_q == DONE) && err_q;
`ifdef MISALIGN_TRAP_EN
    assign AddrExc     = (state_q == DONE) && exc_q;
`else
    assign AddrExc     = 1'b0;
`endif

    // Request latch, timeout counter and load result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            err_q         <= 1'b0;
            exc_q         <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            cnt_q         <= 8'd0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'd0;
            read          <= 32'd0;
        end else begin
            if (start) begin
                // A simultaneous read+write request is handled as a write.
                we_q          <= MemWrite;
                uns_q         <= Unsigned;
                size_q        <= Size;
                off_q         <= Addr[1:0];
                err_q         <= 1'b0;
                exc_q         <= trap;
                cnt_q         <= 8'd0;
                bus.bus_we    <= MemWrite;
                bus.bus_addr  <= {Addr[ADDR_W-1:2], 2'b00};
                bus.bus_be    <= lane_be(Size, Addr[1:0]);
                bus.bus_wdata <= lane_wdata(Size, WriteData);
            end
            if (state_q == REQ) cnt_q <= cnt_q + 8'd1;
            if (finish_ok && !we_q) read <= extract_load(bus.bus_rdata, size_q, uns_q, off_q);
            if (finish_to) begin
                err_q <= 1'b1;
                if (!we_q) read <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed bench for data_mem_ctrl with a
// transaction-level reference model and a per-cycle compare process.
module tb_data_mem_ctrl;
    localparam int AW = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, Unsigned;
    logic [1:0]  Size;
    logic [31:0] Addr, WriteData;
    logic        Stall, ReadValid, BusError, AddrExc;
    logic [31:0] read;

    data_mem_ctrl_if #(.ADDR_W(AW)) bus_if ();

    data_mem_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WriteData(WriteData),
        .Stall(Stall), .read(read), .ReadValid(ReadValid), .BusError(BusError),
        .AddrExc(AddrExc), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, req, rv, berr, exc, bchk, we;
        logic [31:0] rd, addr, wd;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0, n_pass = 0;
    logic [31:0] m_read = 32'd0;
    int          stall_run = 0, last_stall = 0, req_run = 0, last_req = 0, n_exc = 0;
    logic [31:0] obs_addr, obs_wd;
    logic [3:0]  obs_be;
    logic        obs_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference rules, written as plain arithmetic on the access description.
    function automatic logic [31:0] m_extract(input logic [31:0] rdata, input logic [1:0] sz,
                                              input logic un, input logic [31:0] ad);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rdata >> (8 * int'(ad[1:0]))) & 32'hFF;
            if (!un && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (rdata >> (ad[1] ? 16 : 0)) & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] ad);
        if (sz == 2'd0) return 4'b0001 << ad[1:0];
        if (sz == 2'd1) return ad[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic stall, input logic req, input logic rv, input logic berr,
                        input logic exc, input logic bchk, input logic [31:0] ad,
                        input logic [3:0] be, input logic we, input logic [31:0] wd);
        exp_t e;
        e.stall = stall; e.req = req; e.rv = rv; e.berr = berr; e.exc = exc;
        e.bchk = bchk; e.addr = ad; e.be = be; e.we = we; e.wd = wd; e.rd = m_read;
        exp_q.push_back(e);
    endtask

    // One access: k = REQ cycle carrying bus_ack (0 = never acknowledged).
    task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd, input int k,
                          input logic [31:0] ack_data);
        logic mis;
        int   n;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 2'd1 && ad[0]) || (sz[1] && ad[1:0] != 2'b00);
`endif
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = un; Addr = ad; WriteData = wd;
        bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
        tick();
        if (!mis) begin
            n = (k == 0) ? TO : k;
            for (int j = 1; j <= n; j++) begin
                bus_if.bus_ack   = (k != 0 && j == k);
                bus_if.bus_rdata = (j == k) ? ack_data : $urandom;
                push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {ad[31:2], 2'b00}, m_be(sz, ad), wr, m_wd(sz, wd));
                if (j == n && !wr) m_read = (k != 0) ? m_extract(ack_data, sz, un, ad) : 32'd0;
                tick();
            end
        end
        bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
        push(1'b0, 1'b0, !wr && !mis && k != 0, !mis && k == 0, mis, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            MemRead = 1'b0; MemWrite = 1'b0; Addr = $urandom;
            bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
            tick();
        end
    endtask

    // Per-cycle comparison of DUT outputs against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Stall", 32'(Stall), 32'(e.stall));
            check("bus_req", 32'(bus_if.bus_req), 32'(e.req));
            check("ReadValid", 32'(ReadValid), 32'(e.rv));
            check("BusError", 32'(BusError), 32'(e.berr));
            check("AddrExc", 32'(AddrExc), 32'(e.exc));
            check("read", read, e.rd);
            if (e.bchk) begin
                check("bus_addr", bus_if.bus_addr, e.addr);
                check("bus_be", 32'(bus_if.bus_be), 32'(e.be));
                check("bus_we", 32'(bus_if.bus_we), 32'(e.we));
                if (e.we) check("bus_wdata", bus_if.bus_wdata, e.wd);
            end
            if (Stall) stall_run++;
            else if (stall_run != 0) begin last_stall = stall_run; stall_run = 0; end
            if (bus_if.bus_req) begin
                req_run++;
                obs_addr = bus_if.bus_addr; obs_be = bus_if.bus_be;
                obs_we = bus_if.bus_we; obs_wd = bus_if.bus_wdata;
            end else if (req_run != 0) begin last_req = req_run; req_run = 0; end
            if (AddrExc) n_exc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, k;
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd0; Unsigned = 1'b0;
        Addr = 32'd0; WriteData = 32'd0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        #12;
        check("rst Stall", 32'(Stall), 32'd0);
        check("rst bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst read", read, 32'd0);
        check("rst ReadValid", 32'(ReadValid), 32'd0);
        check("rst BusError", 32'(BusError), 32'd0);
        check("rst AddrExc", 32'(AddrExc), 32'd0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // Word load, ack in third request cycle.
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 3, 32'hDEADBEEF);
        check("t2 stall cycles", 32'(last_stall), 32'd4);
        check("t2 req cycles", 32'(last_req), 32'd3);
        check("t2 bus_addr", obs_addr, 32'h100);
        check("t2 bus_be", 32'(obs_be), 32'hF);
        check("t2 bus_we", 32'(obs_we), 32'd0);
        check("t2 read", read, 32'hDEADBEEF);
        idle(1);

        // Byte/half load extraction.
        do_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 1, 32'h80112233);
        check("t3 byte signed", read, 32'hFFFFFF80);
        do_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 2, 32'h80112233);
        check("t3 byte unsigned", read, 32'h00000080);
        do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 1, 32'h80112233);
        check("t3 half signed", read, 32'hFFFF8011);

        // Half store.
        do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 2, 32'h0);
        check("t4 bus_addr", obs_addr, 32'h200);
        check("t4 bus_be", 32'(obs_be), 32'hC);
        check("t4 bus_wdata", obs_wd, 32'hABCDABCD);
        check("t4 bus_we", 32'(obs_we), 32'd1);
        check("t4 read kept", read, 32'hFFFF8011);

        // Misaligned word load.
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 1, 32'h12345678);
`ifdef MISALIGN_TRAP_EN
        check("t6 trap count", 32'(n_exc), 32'd1);
        check("t6 read kept", read, 32'hFFFF8011);
`else
        check("t6 bus_addr", obs_addr, 32'h100);
        check("t6 read", read, 32'h12345678);
`endif

        // Load that is never acknowledged.
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 0, 32'h0);
        check("t5 req cycles", 32'(last_req), 32'd4);
        check("t5 stall cycles", 32'(last_stall), 32'd5);
        check("t5 read", read, 32'd0);

        // Randomized accesses, back-to-back or with idle gaps.
        for (int t = 0; t < 200; t++) begin
            r = $urandom % 3;
            k = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, TO));
            do_txn(r != 1, r != 0, 2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom, k, $urandom);
            if ($urandom % 3 == 0) idle(int'($urandom % 3));
        end

        // Reset asserted mid-request, then a late acknowledge.
        do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 1, 32'hCAFEF00D);
        MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Addr = 32'h500; bus_if.bus_ack = 1'b0;
        tick();
        check("t1 in request", 32'(bus_if.bus_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t1 bus_req", 32'(bus_if.bus_req), 32'd0);
        check("t1 Stall", 32'(Stall), 32'd0);
        check("t1 read", read, 32'd0);
        m_read = 32'd0;
        tick();
        bus_if.bus_ack = 1'b1;
        tick();
        rst_n = 1'b1; MemRead = 1'b0;
        bus_if.bus_ack = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
        tick();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Multi-cycle data-memory access controller in the MEM stage, directly upstream of the read-data gate.
- Takes load/store requests from the pipeline and runs a req/ack handshake to a wait-stated data-memory bus.
- Stalls the pipeline until the bus access completes.
- Aligns and sign/zero-extends load data, and produces the 32-bit `read` word that the MemRead-qualified read gate passes to write-back.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 255, max REQ cycles without bus_ack before a bus error is forced (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request, held stable by pipeline while Stall=1.
- MemWrite  in  1  store request, held stable while Stall=1.
- Size  in  2  00 byte, 01 half, 10/11 word.
- Unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- Addr  in  ADDR_W  byte address.
- WriteData  in  32  store data, right-justified.
- Stall  out  1  freeze pipeline.
- read  out  32  aligned/extended load data to read gate.
- ReadValid  out  1  one-cycle pulse: read updated.
- BusError  out  1  one-cycle pulse: access timed out.
- AddrExc  out  1  one-cycle pulse: misaligned access trapped (see Optional Feature).
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, Addr with [1:0]=00.
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  access complete; bus_rdata valid in the same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including read; timeout counter 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if MemRead|MemWrite, Stall=1 (combinational), latch Addr/Size/Unsigned/WriteData/we, go REQ. Otherwise Stall=0.
  - REQ: bus_req=1 and registered bus_* fields held stable; Stall=1.
    - bus_ack=1: capture bus_rdata (read only), go DONE.
    - Counter reaches TIMEOUT: go DONE with error flag.
  - DONE: Stall=0 for exactly one cycle, bus_req=0, go IDLE.
    - Read: ReadValid=1 and read = extracted data.
    - Error: BusError=1, read=0, ReadValid=0.
- Latency: ack in the k-th REQ cycle gives Stall high for k+1 cycles and ReadValid in the next cycle. Minimum access is 3 cycles (IDLE, REQ, DONE).
- Back-to-back: the next request is sampled in IDLE after DONE, with no lost requests.
- MemRead and MemWrite both high: treated as a write; read unchanged.
- Load extraction, off = Addr[1:0]:
  - Byte = rdata[8*off+7:8*off].
  - Half = rdata[16*Addr[1]+15:16*Addr[1]].
  - Extend to 32 bits per Unsigned.
- Store: bus_wdata = byte replicated x4, half x2, or word.
  - bus_be: byte 0001<<off; half 0011<<(2*Addr[1]); word 1111.
- Misaligned accesses without the macro: low address bits are ignored for the selected size (half ignores Addr[0]; word ignores Addr[1:0]).
- Writes never modify read. read holds its value until the next successful load.
- bus_ack outside REQ is ignored.
- Reset mid-REQ: bus_req drops asynchronously, state returns to IDLE, and a late bus_ack is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Half with Addr[0]=1, or word with Addr[1:0]!=00, trapped in IDLE.
  - No bus_req issued; go straight to DONE.
  - AddrExc=1 in DONE; read unchanged; ReadValid=0; Stall high 1 cycle.
- Undefined: AddrExc tied 0; misaligned accesses handled as above.

Test Plan:
1. rst_n=0 asserted mid-cycle during REQ -> bus_req, Stall, read immediately 0; state IDLE; bus_ack one cycle later ignored.
2. Word load Addr=0x100, bus_ack in 3rd REQ cycle with bus_rdata=0xDEADBEEF -> Stall high 4 cycles, bus_addr=0x100, bus_be=1111, bus_we=0; next cycle ReadValid=1, read=0xDEADBEEF.
3. Byte load Addr=0x103, bus_rdata=0x80112233 -> Unsigned=0: read=0xFFFFFF80; Unsigned=1: read=0x00000080. Half load Addr=0x102 signed -> 0xFFFF8011.
4. Half store Addr=0x202, WriteData=0x0000ABCD -> bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1; read unchanged; ReadValid=0.
5. TIMEOUT=4, load with no bus_ack -> bus_req high exactly 4 cycles, then BusError=1 for 1 cycle, read=0, Stall drops with BusError.
6. With MISALIGN_TRAP_EN defined, word load Addr=0x101 -> no bus_req, AddrExc=1 in next cycle, read unchanged. Without the macro: bus_addr=0x100 and normal completion.
